// File: rtl/versat_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : versat_bus_master
// Description : Burst initiator for the Versat native memory-mapped bus.
//               A write command streams cmd_len words from the write-data
//               stream to consecutive word addresses. A read command fetches
//               cmd_len consecutive words and presents them on the read
//               stream. Each bus access can be aborted by a wait timeout.
// Ports       : clk/rst_n            clock, asynchronous active-low reset
//               cmd_*                command handshake (dir, addr, len)
//               wr_valid/ready/data  write-data stream into the master
//               rd_valid/ready/data  read-data stream out of the master
//               valid/addr/wstrb/wdata/ready/rdata  Versat bus
//               done/err             end-of-command pulse and abort flag
// Revision    : 1.0 - initial release
// ============================================================================
module versat_bus_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 10,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                valid,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   wdata,
  input  logic                ready,
  input  logic [DATA_W-1:0]   rdata,
  output logic                done,
  output logic                err
);

  // The wait counter only has to reach TIMEOUT-1: the abort is taken in the
  // cycle that would have made it TIMEOUT.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_REQ   = 3'd2,
    S_PUSH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                timeout_hit;

  // A ready in the same cycle still wins, because ready is tested first.
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          write_d = cmd_write;
          wstrb_d = cmd_write ? '1 : '0;
          err_d   = 1'b0;
          wait_d  = '0;
          if (cmd_len == '0)   state_d = S_DONE;
          else if (cmd_write)  state_d = S_FETCH;
          else                 state_d = S_REQ;
        end
      end
      S_FETCH: begin
        if (wr_valid) begin
          wdata_d = wr_data;
          wait_d  = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ready) begin
          addr_d = addr_q + 1'b1;
          len_d  = len_q - 1'b1;
          if (write_q) begin
            state_d = (len_q == LEN_W'(1)) ? S_DONE : S_FETCH;
          end else begin
            rdata_d = rdata;
            state_d = S_PUSH;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (TIMEOUT != 0) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_PUSH: begin
        // len_q was already decremented when the word was fetched.
        if (rd_ready) begin
          wait_d  = '0;
          state_d = (len_q == '0) ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign wr_ready  = (state_q == S_FETCH);
  assign valid     = (state_q == S_REQ);
  assign rd_valid  = (state_q == S_PUSH);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_DONE) && err_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign rd_data   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_versat_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_versat_bus_master
// Description : Self-checking bench for versat_bus_master. Bus accesses and
//               read-stream words are predicted into scoreboard queues when a
//               command is issued and popped as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_versat_bus_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [9:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        valid;
  logic [11:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        done, err;

  versat_bus_master #(
    .ADDR_W(12), .DATA_W(32), .LEN_W(10), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .valid(valid), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .ready(ready), .rdata(rdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [11:0] a;
    logic [31:0] d;
  } bus_t;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [9:0]  len;
    int          waitst;
    int          stall;
    logic [31:0] d0;
    int          dmin;
    int          dmax;
    int          vcyc;
    bit          eerr;
  } vec_t;

  bus_t        bus_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int resp_wait, rd_stall, wcnt, scnt, vcount, whs;
  bit resp_never;
  bit pend;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  vec_t vecs[8];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic fail(input string n);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", n, cyc);
  endtask

  // One clock: react to the outputs seen now, then advance to just after
  // the next rising edge.
  task automatic tick();
    bus_t        e;
    logic [31:0] r;
    if (pend) begin
      chk("hold_valid", {31'h0, valid}, 32'h1);
      chk("hold_addr", {20'h0, addr}, {20'h0, paddr});
      chk("hold_wdata", wdata, pwdata);
    end
    chk("err_without_done", {31'h0, err & ~done}, 32'h0);
    chk("valid_while_rd_valid", {31'h0, valid & rd_valid}, 32'h0);
    ready = 1'b0;
    rdata = 32'hDEADBEEF;
    if (valid) begin
      vcount++;
      if (!resp_never && wcnt >= resp_wait) begin
        ready = 1'b1;
        rdata = {20'h0, addr ^ 12'h055};
        wcnt  = 0;
        pend  = 1'b0;
        if (bus_q.size() == 0) begin
          fail("bus_unexpected_access");
        end else begin
          e = bus_q.pop_front();
          chk("bus_addr", {20'h0, addr}, {20'h0, e.a});
          chk("bus_wstrb", {28'h0, wstrb}, e.wr ? 32'hF : 32'h0);
          if (e.wr) chk("bus_wdata", wdata, e.d);
        end
      end else begin
        wcnt++;
        pend   = !resp_never;
        paddr  = addr;
        pwdata = wdata;
      end
    end else begin
      pend = 1'b0;
    end
    if (wr_q.size() > 0) begin
      wr_valid = 1'b1;
      wr_data  = wr_q[0];
      if (wr_ready) begin
        wr_q.delete(0);
        whs++;
      end
    end else begin
      wr_valid = 1'b0;
      wr_data  = '0;
    end
    rd_ready = 1'b0;
    if (rd_valid) begin
      if (scnt < rd_stall) begin
        scnt++;
      end else begin
        rd_ready = 1'b1;
        scnt     = 0;
        if (rd_q.size() == 0) begin
          fail("rd_unexpected_word");
        end else begin
          r = rd_q.pop_front();
          chk("rd_data", rd_data, r);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Offer a command, return the done latency (cycles after the accept cycle).
  task automatic issue(input bit wr, input logic [11:0] a, input logic [9:0] len,
                       output int dc);
    int start;
    int n;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = len;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) fail("cmd_ready_timeout");
    start = cyc;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    if (!done) fail("done_timeout");
    dc = cyc - start;
  endtask

  task automatic run_vec(input vec_t v);
    logic [11:0] a;
    int          dc;
    resp_wait  = v.waitst;
    resp_never = 1'b0;
    rd_stall   = v.stall;
    vcount = 0; whs = 0; wcnt = 0; scnt = 0;
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.addr + 12'(i);
      bus_q.push_back({v.wr, a, v.d0 + 32'(i)});
      if (v.wr) wr_q.push_back(v.d0 + 32'(i));
      else      rd_q.push_back({20'h0, a ^ 12'h055});
    end
    issue(v.wr, v.addr, v.len, dc);
    if (dc < v.dmin || dc > v.dmax) begin
      checks++;
      failures++;
      $display("FAIL done_latency: got %0d expected %0d..%0d", dc, v.dmin, v.dmax);
    end else begin
      checks++;
    end
    chk("err_at_done", {31'h0, err}, {31'h0, v.eerr});
    tick();
    chk("done_one_cycle", {31'h0, done}, 32'h0);
    chk("cmd_ready_after", {31'h0, cmd_ready}, 32'h1);
    chk("valid_cycles", vcount, v.vcyc);
    chk("wr_handshakes", whs, v.wr ? 32'(v.len) : 32'h0);
    chk("bus_q_drained", bus_q.size(), 32'h0);
    chk("rd_q_drained", rd_q.size(), 32'h0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, {31'h0, cmd_ready}, 32'h1);
    chk({tag, "_valid"},     {31'h0, valid},     32'h0);
    chk({tag, "_wr_ready"},  {31'h0, wr_ready},  32'h0);
    chk({tag, "_rd_valid"},  {31'h0, rd_valid},  32'h0);
    chk({tag, "_done"},      {31'h0, done},      32'h0);
    chk({tag, "_err"},       {31'h0, err},       32'h0);
    chk({tag, "_addr"},      {20'h0, addr},      32'h0);
    chk({tag, "_wstrb"},     {28'h0, wstrb},     32'h0);
    chk({tag, "_wdata"},     wdata,              32'h0);
    chk({tag, "_rd_data"},   rd_data,            32'h0);
  endtask

  initial begin
    int dc;
    //            wr    addr     len    wt st d0        dmin dmax vcyc err
    vecs[0] = '{1'b1, 12'h400, 10'd4, 0, 0, 32'hA0, 9,  9,  4, 1'b0};
    vecs[1] = '{1'b0, 12'h010, 10'd3, 0, 2, 32'h0,  13, 13, 3, 1'b0};
    vecs[2] = '{1'b1, 12'h020, 10'd2, 3, 0, 32'h11, 11, 11, 8, 1'b0};
    vecs[3] = '{1'b0, 12'hFFE, 10'd4, 0, 0, 32'h0,  9,  9,  4, 1'b0};
    vecs[4] = '{1'b1, 12'h100, 10'd0, 0, 0, 32'h0,  1,  2,  0, 1'b0};
    vecs[5] = '{1'b0, 12'h030, 10'd1, 7, 0, 32'h0,  10, 10, 8, 1'b0};
    vecs[6] = '{1'b1, 12'h040, 10'd1, 7, 0, 32'h5A, 10, 10, 8, 1'b0};
    vecs[7] = '{1'b1, 12'hFFF, 10'd2, 1, 0, 32'h77, 7,  7,  4, 1'b0};

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    ready = 1'b0; rdata = '0;
    pend = 1'b0; resp_never = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Responder never answers: 8 valid cycles, abort with err, one word taken.
    resp_never = 1'b1;
    vcount = 0; whs = 0; wcnt = 0; scnt = 0;
    wr_q.push_back(32'hC0);
    wr_q.push_back(32'hC1);
    wr_q.push_back(32'hC2);
    issue(1'b1, 12'h200, 10'd3, dc);
    chk("timeout_done_latency", dc, 32'd10);
    chk("timeout_err", {31'h0, err}, 32'h1);
    repeat (4) tick();
    chk("timeout_valid_cycles", vcount, 32'd8);
    chk("timeout_wr_handshakes", whs, 32'd1);
    chk("timeout_wr_left", wr_q.size(), 32'd2);
    wr_q.delete();
    tick();

    // Asynchronous reset while a read is waiting on the bus.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h300; cmd_len = 10'd4;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("midburst_valid", {31'h0, valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("midburst_reset");
    @(negedge clk);
    rst_n = 1'b1;
    pend = 1'b0;
    resp_never = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("post_reset_done", {31'h0, done}, 32'h0);
    chk("post_reset_valid", {31'h0, valid}, 32'h0);

    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
